// File: rtl/fifo_word_packer_if.sv
// fifo_word_packer_if
// Bundles the two handshakes around the packer into one port.
//   FIFO side   : empty (to packer), r_en (from packer), fifo_data (to packer)
//   Output side : out_data, out_keep, out_valid (from packer), out_ready (to packer)
// The master modport is the packer's view.
// The slave modport is the view of whoever drives the FIFO and consumes the words.
interface fifo_word_packer_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4
);
  logic                                 empty;
  logic                                 r_en;
  logic [DATA_WIDTH-1:0]                fifo_data;
  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] out_data;
  logic [BYTES_PER_WORD-1:0]            out_keep;
  logic                                 out_valid;
  logic                                 out_ready;

  modport master (
    input  empty, fifo_data, out_ready,
    output r_en, out_data, out_keep, out_valid
  );

  modport slave (
    output empty, fifo_data, out_ready,
    input  r_en, out_data, out_keep, out_valid
  );
endinterface

// File: rtl/fifo_word_packer.sv
// fifo_word_packer
// Pops bytes from a synchronous FIFO with one cycle of registered read latency.
// Packs every BYTES_PER_WORD bytes into one wide word and offers it on a
// valid/ready output. If the FIFO stays dry for TIMEOUT cycles, a partial word
// is flushed, and a keep mask marks which lanes are real.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : fifo_word_packer_if.master
//          (empty/r_en/fifo_data toward the FIFO; out_* toward downstream)
module fifo_word_packer #(
  parameter int DATA_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input logic                clk,
  input logic                rst,
  fifo_word_packer_if.master bus
);

  localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam int WORD_W = DATA_WIDTH * BYTES_PER_WORD;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_rdPend;
  logic [TMR_W-1:0]          r_timer;
  logic [WORD_W-1:0]         r_data;
  logic [BYTES_PER_WORD-1:0] r_keep;

  logic                      w_rEn;
  logic                      w_idle;
  logic                      w_lastLane;
  logic                      w_expire;
  logic                      w_accept;
  logic [BYTES_PER_WORD-1:0] w_flushKeep;

  // Next-state and strobe decode.
  // A read is only issued when the lanes already captured plus the one in
  // flight leave room, so a word boundary is never overrun. The read strobe
  // is also masked during reset, so nothing is popped that reset would
  // throw away.
  // An idle cycle is one where a partial word sits waiting and nothing is
  // moving. On the idle cycle where the timer has already seen TIMEOUT-1
  // idles, the partial word is flushed.
  always_comb begin
    w_nextState = r_state;
    w_rEn       = 1'b0;
    w_idle      = 1'b0;
    w_expire    = 1'b0;
    w_accept    = 1'b0;
    w_lastLane  = r_rdPend && (int'(r_cnt) == BYTES_PER_WORD - 1);
    w_flushKeep = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      w_flushKeep[i] = (i < int'(r_cnt));
    end
    case (r_state)
      FILL: begin
        w_rEn    = !rst && !bus.empty &&
                   ((int'(r_cnt) + int'(r_rdPend)) < BYTES_PER_WORD);
        w_idle   = (r_cnt != '0) && !r_rdPend && !w_rEn;
        w_expire = w_idle && (int'(r_timer) == TIMEOUT - 1);
        if (w_lastLane || w_expire) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        w_accept = bus.out_ready;
        if (w_accept) begin
          w_nextState = FILL;
        end
      end
      default: w_nextState = FILL;
    endcase
  end

  // State register only; all decisions live in the combinational block above.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Lane capture, lane counter, idle timer and the output word/keep registers.
  // The output registers double as the assembly buffer. Clearing them on
  // acceptance is what keeps the unused lanes of a flushed word at zero.
  // The in-flight flag simply follows the read strobe. Reset clears it, so
  // the byte returned right after reset is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rdPend <= 1'b0;
      r_timer  <= '0;
      r_data   <= '0;
      r_keep   <= '0;
    end else begin
      r_rdPend <= w_rEn;
      if (w_accept) begin
        r_cnt   <= '0;
        r_timer <= '0;
        r_data  <= '0;
        r_keep  <= '0;
      end else begin
        if (r_rdPend) begin
          r_data[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= bus.fifo_data;
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_lastLane) begin
          r_keep <= '1;
        end else if (w_expire) begin
          r_keep <= w_flushKeep;
        end
        if (w_idle && !w_expire) begin
          r_timer <= r_timer + 1'b1;
        end else begin
          r_timer <= '0;
        end
      end
    end
  end

  assign bus.r_en      = w_rEn;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_data  = r_data;
  assign bus.out_keep  = r_keep;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer
// Drives fifo_word_packer through a behavioural FIFO model with one cycle of
// read latency. Expected output words are queued as bytes are offered.
// A monitor pops the queue on every accepted word and compares.
`timescale 1ns/1ps
module tb_fifo_word_packer;

  localparam int DW  = 8;
  localparam int BPW = 4;
  localparam int TO  = 16;
  localparam int WW  = DW * BPW;

  typedef struct {
    logic [WW-1:0]  data;
    logic [BPW-1:0] keep;
  } exp_t;

  logic clk;
  logic rst;

  fifo_word_packer_if #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW)) bus();

  fifo_word_packer #(.DATA_WIDTH(DW), .BYTES_PER_WORD(BPW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t          expQ[$];
  logic [DW-1:0] fifoQ[$];

  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   rEnCount    = 0;
  int   lastREnCyc  = 0;
  int   riseCyc     = 0;
  int   validCycles = 0;
  int   emptyViol   = 0;
  int   stabViol    = 0;
  int   base        = 0;
  bit   rEnSeen     = 0;
  bit   prevValid   = 0;
  bit   prevStall   = 0;
  bit   randReady   = 0;
  logic [WW-1:0]  prevData;
  logic [BPW-1:0] prevKeep;

  // Free-running clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic refreshEmpty();
    bus.empty = (fifoQ.size() == 0);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] b);
    fifoQ.push_back(b);
    refreshEmpty();
  endtask

  task automatic expectWord(input logic [WW-1:0] d, input logic [BPW-1:0] k);
    exp_t e;
    e.data = d;
    e.keep = k;
    expQ.push_back(e);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO model: a strobe seen in one cycle returns the head byte shortly after the next edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (rEnSeen && fifoQ.size() > 0) bus.fifo_data = fifoQ.pop_front();
    refreshEmpty();
  end

  // Random downstream backpressure, only while enabled.
  initial forever begin
    @(posedge clk);
    #2;
    if (randReady) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor on the falling edge: strobe bookkeeping, hold stability and scoreboard.
  initial forever begin
    @(negedge clk);
    rEnSeen = bus.r_en;
    if (bus.r_en) begin
      rEnCount++;
      lastREnCyc = cyc;
      if (bus.empty) emptyViol++;
    end
    if (bus.out_valid && !prevValid) riseCyc = cyc;
    if (bus.out_valid) validCycles++;
    if (prevStall && bus.out_valid && (bus.out_data !== prevData || bus.out_keep !== prevKeep)) stabViol++;
    prevStall = bus.out_valid && !bus.out_ready;
    prevData  = bus.out_data;
    prevKeep  = bus.out_keep;
    prevValid = bus.out_valid;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_word", {32'h0, bus.out_data}, 64'hDEAD_0000_0000_0000);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("word_data", {32'h0, bus.out_data}, {32'h0, e.data});
        checkOutput("word_keep", {60'h0, bus.out_keep}, {60'h0, e.keep});
      end
    end
  end

  // Watchdog so a stuck run still ends with a report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst           = 1'b1;
    bus.empty     = 1'b1;
    bus.fifo_data = '0;
    bus.out_ready = 1'b0;
    waitCycles(3);
    checkOutput("reset_out_valid", {63'h0, bus.out_valid}, 64'h0);
    checkOutput("reset_out_data", {32'h0, bus.out_data}, 64'h0);
    checkOutput("reset_out_keep", {60'h0, bus.out_keep}, 64'h0);
    checkOutput("reset_r_en", {63'h0, bus.r_en}, 64'h0);

    // Basic pack, bytes preloaded during reset.
    bus.out_ready = 1'b1;
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    expectWord(32'h44332211, 4'b1111);
    waitCycles(1);
    checkOutput("reset_r_en_gated", {63'h0, bus.r_en}, 64'h0);
    rEnCount    = 0;
    validCycles = 0;
    base        = cyc;
    rst         = 1'b0;
    waitCycles(12);
    checkOutput("basic_ren_pulses", 64'(rEnCount), 64'd4);
    checkOutput("basic_valid_cycle", 64'(riseCyc - base), 64'd5);
    checkOutput("basic_valid_len", 64'(validCycles), 64'd1);

    // Backpressure.
    bus.out_ready = 1'b0;
    rEnCount      = 0;
    stabViol      = 0;
    for (int i = 1; i <= 8; i++) applyStimulus(8'(i));
    expectWord(32'h04030201, 4'b1111);
    expectWord(32'h08070605, 4'b1111);
    waitCycles(15);
    checkOutput("bp_ren_pulses", 64'(rEnCount), 64'd4);
    checkOutput("bp_valid_held", {63'h0, bus.out_valid}, 64'h1);
    checkOutput("bp_data_held", {32'h0, bus.out_data}, 64'h04030201);
    bus.out_ready = 1'b1;
    waitCycles(20);
    checkOutput("bp_stable", 64'(stabViol), 64'd0);
    checkOutput("bp_ren_total", 64'(rEnCount), 64'd8);

    // Timeout flush of two lanes.
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    expectWord(32'h0000BBAA, 4'b0011);
    waitCycles(30);
    checkOutput("timeout_latency", 64'(riseCyc - lastREnCyc), 64'(TO + 2));

    // Timer restart: second byte after 10 idle cycles.
    validCycles = 0;
    applyStimulus(8'hC1);
    expectWord(32'h0000C2C1, 4'b0011);
    waitCycles(12);
    applyStimulus(8'hC2);
    waitCycles(8);
    checkOutput("restart_no_early_flush", 64'(validCycles), 64'd0);
    waitCycles(20);
    checkOutput("restart_latency", 64'(riseCyc - lastREnCyc), 64'(TO + 2));

    // Read arriving on the very cycle the timer would expire wins.
    applyStimulus(8'hD1);
    expectWord(32'h0000D2D1, 4'b0011);
    waitCycles(17);
    applyStimulus(8'hD2);
    waitCycles(30);
    checkOutput("expire_race_latency", 64'(riseCyc - lastREnCyc), 64'(TO + 2));

    // Random empty/backpressure with short gaps so no timeout fires.
    begin
      logic [WW-1:0] cur;
      cur       = '0;
      emptyViol = 0;
      randReady = 1;
      for (int i = 0; i < 240; i++) begin
        logic [DW-1:0] b;
        b = 8'(i * 37 + 5);
        cur[(i % BPW)*DW +: DW] = b;
        applyStimulus(b);
        if (i % BPW == BPW - 1) expectWord(cur, 4'b1111);
        waitCycles(int'($urandom_range(0, 4)));
      end
      randReady     = 0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3000 && expQ.size() > 0; k++) waitCycles(1);
      checkOutput("rand_drain", 64'(expQ.size()), 64'd0);
      checkOutput("rand_fifo_drained", 64'(fifoQ.size()), 64'd0);
      checkOutput("rand_empty_safety", 64'(emptyViol), 64'd0);
    end

    // Mid-operation reset after two captures with a third byte in flight.
    waitCycles(5);
    applyStimulus(8'h51);
    applyStimulus(8'h52);
    applyStimulus(8'h53);
    applyStimulus(8'h54);
    waitCycles(3);
    rst = 1'b1;
    waitCycles(1);
    rst = 1'b0;
    checkOutput("midrst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    checkOutput("midrst_out_data", {32'h0, bus.out_data}, 64'h0);
    checkOutput("midrst_out_keep", {60'h0, bus.out_keep}, 64'h0);
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    applyStimulus(8'h63);
    expectWord(32'h63626154, 4'b1111);
    waitCycles(20);
    checkOutput("final_scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
